// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path and its bus decode.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  localparam int STAT_RDA  = 0;
  localparam int STAT_PERR = 1;
  localparam int STAT_FERR = 2;
  localparam int STAT_OVR  = 3;
  localparam int STAT_FULL = 4;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module spart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone defines which
  // entries are valid, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled UART deserialiser with false-start filter,
// optional parity, per-byte error flags and a bus-readable receive FIFO.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun
);

  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int ENT_W  = DATA_BITS + 2;
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic              ODD       = 1'(PARITY_ODD);

  rx_state_t             state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  wait_high_q, wait_high_d;
  logic                  overrun_q, overrun_d;

  logic                  rxd_s, push, ferr;
  logic                  rd_data_sel, rd_stat_sel, pop;
  logic [ENT_W-1:0]      head;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [7:0]            status;

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    wait_high_d = wait_high_q;
    push        = 1'b0;
    ferr        = 1'b0;
    case (state_q)
      IDLE: begin
        // After a framing error the line may still be in a break; hold off
        // start detection until it has gone high again.
        if (wait_high_q) begin
          if (rxd_s) wait_high_d = 1'b0;
        end else if (!rxd_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: if (enable) begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == HALF_TICK) begin
          tick_d  = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: if (enable) begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (enable) begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          perr_d  = ((^shift_q) ^ rxd_s) != ODD;
          state_d = STOP;
        end
      end
      STOP: if (enable) begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == LAST_TICK) begin
          tick_d      = '0;
          push        = 1'b1;
          ferr        = !rxd_s;
          wait_high_d = !rxd_s;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data_sel = iocs && iorw && (ioaddr == ADDR_DATA);
  assign rd_stat_sel = iocs && iorw && (ioaddr == ADDR_STATUS);
  assign pop         = rd_data_sel && !fifo_empty;

  // Set wins over a same-cycle status-read clear.
  always_comb begin
    overrun_d = overrun_q;
    if (rd_stat_sel) overrun_d = 1'b0;
    if (push && fifo_full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      wait_high_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      wait_high_q <= wait_high_d;
      overrun_q   <= overrun_d;
    end
  end

  spart_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({ferr, perr_q, shift_q}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rda     = (fifo_count != '0);
  assign overrun = overrun_q;

  always_comb begin
    status            = '0;
    status[STAT_RDA]  = rda;
    status[STAT_PERR] = !fifo_empty && head[DATA_BITS];
    status[STAT_FERR] = !fifo_empty && head[DATA_BITS+1];
    status[STAT_OVR]  = overrun_q;
    status[STAT_FULL] = fifo_full;
  end

  assign rx_data = rd_data_sel ? (fifo_empty ? 8'h00 : 8'(head[DATA_BITS-1:0])) :
                   rd_stat_sel ? status : 8'hzz;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Randomised scoreboard bench for spart_rx_fifo (8 data bits, even parity,
// 4-entry FIFO, enable every cycle).
module tb_spart_rx_fifo;

  localparam int DB    = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int P_EN  = 1;
  localparam int P_ODD = 0;
  // Edges from the edge after which rxd falls until the stop-sample push edge.
  localparam int PUSH_EDGE = 3 + OS / 2 + OS * (DB + P_EN + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       rxd = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] rx_data;
  wire        rda;
  wire        overrun;

  spart_rx_fifo #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .PARITY_EN  (P_EN),
    .PARITY_ODD (P_ODD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .rxd     (rxd),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .rx_data (rx_data),
    .rda     (rda),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       fe;
    bit       pe;
    bit [7:0] d;
  } entry_t;

  entry_t     mq[$];
  bit         movr;
  logic [7:0] exp_q[$];
  string      name_q[$];
  string      phase = "reset";
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  function automatic void model_push(input bit fe, input bit pe, input bit [7:0] d);
    entry_t e;
    e.fe = fe; e.pe = pe; e.d = d;
    if (mq.size() < DEPTH) mq.push_back(e);
    else movr = 1'b1;
  endfunction

  function automatic void model_reset();
    mq.delete();
    movr = 1'b0;
  endfunction

  // Monitor: compares every data/status read against the queued expectation.
  always @(negedge clk) begin
    if (iocs && iorw && !ioaddr[1]) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: got %02h expected none", rx_data);
      end else begin
        check(name_q.pop_front(), rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic bus_read(input logic [1:0] a, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      if (a == 2'b00) begin
        if (mq.size() == 0) e = 8'h00;
        else begin
          e = mq[0].d;
          void'(mq.pop_front());
        end
        exp_q.push_back(e);
        name_q.push_back({phase, "/data"});
      end else if (a == 2'b01) begin
        e = 8'h00;
        if (mq.size() != 0) e = {3'b000, mq.size() == DEPTH, movr, mq[0].fe, mq[0].pe, 1'b1};
        else e[3] = movr;
        movr = 1'b0;
        exp_q.push_back(e);
        name_q.push_back({phase, "/status"});
      end
    end
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
  endtask

  task automatic bus_write(input logic [1:0] a);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a;
    @(posedge clk); #1;
    iocs = 1'b0; ioaddr = 2'b00;
  endtask

  task automatic send_frame(input bit [7:0] d, input bit bad_par, input bit bad_stop,
                            input int hold_bits);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < DB; i++) begin
      repeat (OS) @(posedge clk);
      #1 rxd = d[i];
    end
    repeat (OS) @(posedge clk);
    #1 rxd = (^d) ^ P_ODD[0] ^ bad_par;
    repeat (OS) @(posedge clk);
    #1 rxd = !bad_stop;
    repeat (OS + (bad_stop ? hold_bits * OS : 0)) @(posedge clk);
    #1 rxd = 1'b1;
    model_push(bad_stop, bad_par, d);
    repeat (8) @(posedge clk);
  endtask

  task automatic check_rda(input string nm, input bit exp);
    @(negedge clk);
    check(nm, {7'd0, rda}, {7'd0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_rda("reset/rda", 1'b0);
    bus_read(2'b01, 1);
    bus_read(2'b10, 1);
    bus_read(2'b11, 1);
    bus_read(2'b00, 1);

    phase = "basic";
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      begin
        repeat (PUSH_EDGE) @(posedge clk);
        check_rda("basic/rda_before_push", 1'b0);
        @(posedge clk);
        check_rda("basic/rda_after_push", 1'b1);
      end
    join
    bus_read(2'b00, 1);
    bus_read(2'b01, 1);

    phase = "glitch";
    @(posedge clk); #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (3 * OS) @(posedge clk);
    check_rda("glitch/rda", 1'b0);
    bus_read(2'b01, 1);

    phase = "parity";
    send_frame(8'h03, 1'b0, 1'b0, 0);
    send_frame(8'h03, 1'b1, 1'b0, 0);
    bus_read(2'b01, 1);
    bus_read(2'b00, 1);
    bus_read(2'b01, 1);
    bus_read(2'b00, 1);
    bus_read(2'b01, 1);

    phase = "framing";
    send_frame(8'h55, 1'b0, 1'b1, 2);
    bus_read(2'b01, 1);
    repeat (250) @(posedge clk);
    bus_read(2'b00, 1);
    bus_read(2'b01, 1);

    phase = "overrun";
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 0);
    bus_read(2'b01, 1);
    bus_read(2'b01, 1);
    bus_write(2'b01);
    bus_read(2'b00, 4);
    bus_read(2'b01, 1);

    phase = "push_pop_full";
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 0);
    fork
      send_frame(8'h24, 1'b0, 1'b0, 0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        bus_read(2'b00, 1);
      end
    join
    bus_read(2'b01, 1);
    bus_read(2'b00, 4);
    bus_read(2'b01, 1);

    phase = "reset_mid_frame";
    send_frame(8'h30, 1'b0, 1'b0, 0);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (OS * 4) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rxd = 1'b1;
    check_rda("reset_mid_frame/rda", 1'b0);
    repeat (2 * OS) @(posedge clk);
    bus_read(2'b01, 1);
    send_frame(8'h31, 1'b0, 1'b0, 0);
    bus_read(2'b00, 1);
    bus_read(2'b01, 1);

    phase = "random";
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 1)));
      for (int r = 0; r < int'($urandom_range(0, 2)); r++)
        bus_read(2'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      if ($urandom_range(0, 4) == 0) bus_write(2'($urandom_range(0, 3)));
    end
    bus_read(2'b01, 1);
    bus_read(2'b00, DEPTH + 1);
    bus_read(2'b01, 1);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
